param_datapath: RTL and testbench

- Parametrised successor to the single-cycle register-file datapath.
- Contains an NREGS x WIDTH register file, a 2-stage issue/execute pipeline with full bypass, and dual-issue (two results per instruction).
- Provides SIMD lane splitting (1/2/4 lanes), a constant-injection path, a zero-mask of hardwired-zero registers, and registered result flags.
- Sits between the instruction decoder and the memory/IO units.

---
 rtl/param_datapath.sv | 198 +++++++++++++++++++
 tb/tb_param_datapath.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_datapath.sv
// Parametrised register-file datapath: NREGS x WIDTH registers, a two-stage
// issue/execute pipeline with full bypass, dual issue, SIMD lane splitting,
// constant injection, a hardwired-zero register mask and registered flags.
module param_datapath #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [2:0]       op,
  input  logic             form,
  input  logic [1:0]       vec,
  input  logic [AW-1:0]    A,
  input  logic [AW-1:0]    B,
  input  logic [AW-1:0]    C,
  input  logic [AW-1:0]    D,
  input  logic [AW-1:0]    Y1,
  input  logic [AW-1:0]    Y2,
  input  logic [1:0]       write,
  input  logic             const_a,
  input  logic [WIDTH-1:0] constant,
  input  logic [NREGS-1:0] zero_mask,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             busy
);

  // Lanes are built from four quarter-width slices.
  localparam int Q = WIDTH / 4;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SHL1 = 3'd5,
    OP_SHR1 = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  // Bit q set when quarter q begins a new lane.
  function automatic logic [3:0] lane_start(input logic [1:0] v);
    return {v[1], v[1] | v[0], v[1], 1'b1};
  endfunction

  function automatic logic [Q-1:0] qsum(input logic [Q-1:0] a, input logic [Q-1:0] b,
                                        input logic sub, input logic cin);
    return a + (sub ? ~b : b) + Q'(cin);
  endfunction

  function automatic logic qcarry(input logic [Q-1:0] a, input logic [Q-1:0] b,
                                 input logic sub, input logic cin);
    return ({1'b0, a} + {1'b0, (sub ? ~b : b)} + (Q+1)'(cin)) > {1'b0, {Q{1'b1}}};
  endfunction

  // Per-lane ALU: carries ripple between quarters only inside a lane.
  function automatic logic [WIDTH-1:0] alu(input op_e f, input logic [1:0] v,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    logic [3:0]       ls;
    logic [3:0]       le;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] shl;
    logic [WIDTH-1:0] shr;
    logic             sub;
    logic             c;
    logic             cin;
    ls  = lane_start(v);
    le  = {1'b1, ls[3:1]};
    shl = a << 1;
    shr = a >> 1;
    sub = (f == OP_SUB);
    c   = 1'b0;
    r   = '0;
    for (int unsigned q = 0; q < 4; q++) begin
      cin = ls[q] ? sub : c;
      case (f)
        OP_ADD, OP_SUB: r[q*Q +: Q] = qsum(a[q*Q +: Q], b[q*Q +: Q], sub, cin);
        OP_AND:         r[q*Q +: Q] = a[q*Q +: Q] & b[q*Q +: Q];
        OP_OR:          r[q*Q +: Q] = a[q*Q +: Q] | b[q*Q +: Q];
        OP_XOR:         r[q*Q +: Q] = a[q*Q +: Q] ^ b[q*Q +: Q];
        OP_SHL1: begin
          r[q*Q +: Q] = shl[q*Q +: Q];
          if (ls[q]) r[q*Q] = 1'b0;
        end
        OP_SHR1: begin
          r[q*Q +: Q] = shr[q*Q +: Q];
          if (le[q]) r[q*Q + Q - 1] = 1'b0;
        end
        default:        r[q*Q +: Q] = a[q*Q +: Q];
      endcase
      c = qcarry(a[q*Q +: Q], b[q*Q +: Q], sub, cin);
    end
    return r;
  endfunction

  // Carry (ADD) or not-borrow (SUB) out of the most significant lane.
  function automatic logic top_carry(input op_e f, input logic [1:0] v,
                                     input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b);
    logic [3:0] ls;
    logic       sub;
    logic       c;
    ls  = lane_start(v);
    sub = (f == OP_SUB);
    c   = 1'b0;
    for (int unsigned q = 0; q < 4; q++) begin
      c = qcarry(a[q*Q +: Q], b[q*Q +: Q], sub, ls[q] ? sub : c);
    end
    return ((f == OP_ADD) || (f == OP_SUB)) && c;
  endfunction

  logic [WIDTH-1:0] regs [NREGS];

  logic             ex_valid;
  op_e              ex_op;
  logic             ex_form;
  logic [1:0]       ex_vec;
  logic [1:0]       ex_write;
  logic [AW-1:0]    ex_y1;
  logic [AW-1:0]    ex_y2;
  logic [WIDTH-1:0] ex_a1;
  logic [WIDTH-1:0] ex_b1;
  logic [WIDTH-1:0] ex_a2;
  logic [WIDTH-1:0] ex_b2;

  logic [WIDTH-1:0] res1;
  logic [WIDTH-1:0] res2;
  logic             cy1;
  logic             wr1;
  logic             wr2;

  logic [AW-1:0]    src_addr [4];
  logic [WIDTH-1:0] rd_val   [4];

  assign wr1      = ex_write[0];
  assign wr2      = ex_form & ex_write[1];
  assign busy     = ex_valid;
  assign dbg_data = zero_mask[dbg_addr] ? '0 : regs[dbg_addr];
  assign src_addr = '{A, B, C, D};

  // Execute-stage ALUs for both results and the Y1 top-lane carry.
  always_comb begin
    res1 = alu(ex_op, ex_vec, ex_a1, ex_b1);
    res2 = alu(ex_op, ex_vec, ex_a2, ex_b2);
    cy1  = top_carry(ex_op, ex_vec, ex_a1, ex_b1);
  end

  // Operand read with bypass; Y2 checked last so it wins, mask overrides all.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      rd_val[i] = regs[src_addr[i]];
      if (ex_valid && wr1 && (ex_y1 == src_addr[i])) rd_val[i] = res1;
      if (ex_valid && wr2 && (ex_y2 == src_addr[i])) rd_val[i] = res2;
      if (zero_mask[src_addr[i]]) rd_val[i] = '0;
    end
  end

  // Issue-to-execute pipeline register for control fields and operands.
  always_ff @(posedge clk) begin
    ex_op    <= op_e'(op);
    ex_form  <= form;
    ex_vec   <= vec;
    ex_write <= write;
    ex_y1    <= Y1;
    ex_y2    <= Y2;
    ex_a1    <= const_a ? constant : rd_val[0];
    ex_b1    <= rd_val[1];
    ex_a2    <= (const_a && form) ? constant : rd_val[2];
    ex_b2    <= rd_val[3];
  end

  // Execute valid bit, register-file writeback (Y2 after Y1) and flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
      ex_valid   <= 1'b0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
    end else begin
      ex_valid <= in_valid;
      if (ex_valid) begin
        if (wr1 && !zero_mask[ex_y1]) regs[ex_y1] <= res1;
        if (wr2 && !zero_mask[ex_y2]) regs[ex_y2] <= res2;
        if (wr1) begin
          zero_flag  <= (res1 == '0);
          carry_flag <= cy1;
        end
      end
    end
  end

endmodule

// File: tb/tb_param_datapath.sv
// Self-checking bench for param_datapath: directed vector table, hand-written
// reset/write-disable sequences, and randomized traffic against a lane-level
// arithmetic reference model.
module tb_param_datapath;

  localparam int WIDTH = 32;
  localparam int NREGS = 16;
  localparam int AW    = 4;

  localparam int ADD = 0, SUB = 1, AND_ = 2, OR_ = 3, XOR_ = 4, SHL = 5, SHR = 6, PASS = 7;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [2:0]       op;
  logic             form;
  logic [1:0]       vec;
  logic [AW-1:0]    A, B, C, D, Y1, Y2;
  logic [1:0]       write;
  logic             const_a;
  logic [WIDTH-1:0] constant;
  logic [NREGS-1:0] zero_mask;
  logic [AW-1:0]    dbg_addr;
  logic [WIDTH-1:0] dbg_data;
  logic             zero_flag;
  logic             carry_flag;
  logic             busy;

  param_datapath #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op(op), .form(form), .vec(vec),
    .A(A), .B(B), .C(C), .D(D), .Y1(Y1), .Y2(Y2), .write(write), .const_a(const_a),
    .constant(constant), .zero_mask(zero_mask), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          v;
    bit          w1;
    bit          w2;
    int unsigned y1;
    int unsigned y2;
    logic [31:0] r1;
    logic [31:0] r2;
    bit          c;
  } pend_t;

  logic [31:0] mregs [NREGS];
  bit          mz;
  bit          mc;
  pend_t       pend;

  // Split words into lanes and apply the operation to each lane independently.
  function automatic void lane_model(input int opc, input int v, input logic [31:0] a,
                                     input logic [31:0] b, output logic [31:0] res,
                                     output bit cy);
    int nl, lw;
    longint unsigned mask, al, bl, s, wa, wb;
    nl = (v == 0) ? 1 : (v == 1) ? 2 : 4;
    lw = 32 / nl;
    mask = (64'd1 << lw) - 1;
    wa = {32'b0, a};
    wb = {32'b0, b};
    res = '0;
    cy = 0;
    for (int l = 0; l < nl; l++) begin
      al = (wa >> (l * lw)) & mask;
      bl = (wb >> (l * lw)) & mask;
      case (opc)
        ADD:     s = al + bl;
        SUB:     s = al - bl;
        AND_:    s = al & bl;
        OR_:     s = al | bl;
        XOR_:    s = al ^ bl;
        SHL:     s = al << 1;
        SHR:     s = al >> 1;
        default: s = al;
      endcase
      res = res | 32'((s & mask) << (l * lw));
      if (l == nl - 1) begin
        if (opc == ADD) cy = ((s >> lw) != 0);
        if (opc == SUB) cy = (al >= bl);
      end
    end
  endfunction

  function automatic logic [31:0] mread(input int unsigned ad);
    if (zero_mask[ad]) return '0;
    if (pend.v && pend.w2 && pend.y2 == ad) return pend.r2;
    if (pend.v && pend.w1 && pend.y1 == ad) return pend.r1;
    return mregs[ad];
  endfunction

  // One clock: model what the current inputs do, advance both, then compare.
  task automatic tick(input logic [AW-1:0] peek);
    pend_t nx;
    logic [31:0] a1, b1, a2, b2;
    bit          dummy_c;
    logic [NREGS-1:0] zm;
    logic        rs;
    nx = '{default: '0};
    if (in_valid) begin
      a1 = const_a ? constant : mread(A);
      b1 = mread(B);
      a2 = (const_a && form) ? constant : mread(C);
      b2 = mread(D);
      lane_model(int'(op), int'(vec), a1, b1, nx.r1, nx.c);
      lane_model(int'(op), int'(vec), a2, b2, nx.r2, dummy_c);
      nx.v  = 1;
      nx.w1 = write[0];
      nx.w2 = form & write[1];
      nx.y1 = Y1;
      nx.y2 = Y2;
    end
    zm = zero_mask;
    rs = rst_n;
    @(posedge clk);
    if (!rs) begin
      for (int i = 0; i < NREGS; i++) mregs[i] = '0;
      mz = 0;
      mc = 0;
      pend = '{default: '0};
    end else begin
      if (pend.v) begin
        if (pend.w1 && !zm[pend.y1]) mregs[pend.y1] = pend.r1;
        if (pend.w2 && !zm[pend.y2]) mregs[pend.y2] = pend.r2;
        if (pend.w1) begin
          mz = (pend.r1 == 0);
          mc = pend.c;
        end
      end
      pend = nx;
    end
    #1;
    dbg_addr = peek;
    #1;
    chk("model_busy", {31'b0, busy}, {31'b0, pend.v});
    chk("model_zero", {31'b0, zero_flag}, {31'b0, mz});
    chk("model_carry", {31'b0, carry_flag}, {31'b0, mc});
    chk("model_dbg", dbg_data, zero_mask[peek] ? 32'h0 : mregs[peek]);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [2:0]  op;
    logic        form;
    logic [1:0]  vec;
    logic [3:0]  a, b, c, d, y1, y2;
    logic [1:0]  wr;
    logic        ca;
    logic [31:0] k;
    logic [3:0]  chk;
    logic [31:0] exp;
    logic        ez;
    logic        ec;
  } vec_t;

  localparam int NT = 18;
  vec_t tbl [NT];

  function automatic vec_t mk(input int o, input int f, input int v, input int a, input int b,
                              input int c, input int d, input int y1, input int y2,
                              input int wr, input int ca, input logic [31:0] k,
                              input int ck, input logic [31:0] exp, input int ez, input int ec);
    vec_t t;
    t.op = 3'(o); t.form = 1'(f); t.vec = 2'(v);
    t.a = 4'(a); t.b = 4'(b); t.c = 4'(c); t.d = 4'(d); t.y1 = 4'(y1); t.y2 = 4'(y2);
    t.wr = 2'(wr); t.ca = 1'(ca); t.k = k; t.chk = 4'(ck); t.exp = exp;
    t.ez = 1'(ez); t.ec = 1'(ec);
    return t;
  endfunction

  task automatic drive(input vec_t t);
    in_valid = 1; op = t.op; form = t.form; vec = t.vec;
    A = t.a; B = t.b; C = t.c; D = t.d; Y1 = t.y1; Y2 = t.y2;
    write = t.wr; const_a = t.ca; constant = t.k;
  endtask

  task automatic idle();
    in_valid = 0; write = 2'b00;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //   op   fm vec a  b  c  d  y1 y2 wr ca k             chk exp           ez ec
    tbl[0]  = mk(PASS, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 32'd5,        1, 32'd5,        0, 0);
    tbl[1]  = mk(PASS, 0, 0, 0, 0, 0, 0, 2, 0, 1, 1, 32'd7,        2, 32'd7,        0, 0);
    tbl[2]  = mk(ADD,  0, 0, 1, 2, 0, 0, 3, 0, 1, 0, 32'd0,        3, 32'd12,       0, 0);
    tbl[3]  = mk(ADD,  0, 0, 3, 1, 0, 0, 4, 0, 1, 0, 32'd0,        4, 32'd17,       0, 0);
    tbl[4]  = mk(AND_, 1, 0, 1, 1, 2, 2, 5, 5, 3, 0, 32'd0,        5, 32'd7,        0, 0);
    tbl[5]  = mk(ADD,  1, 0, 1, 1, 2, 2, 5, 0, 3, 0, 32'd0,        5, 32'd10,       0, 0);
    tbl[6]  = mk(PASS, 0, 0, 0, 0, 0, 0, 6, 0, 1, 1, 32'h0001FFFF, 6, 32'h0001FFFF, 0, 0);
    tbl[7]  = mk(PASS, 0, 0, 0, 0, 0, 0, 7, 0, 1, 1, 32'h00000001, 7, 32'h00000001, 0, 0);
    tbl[8]  = mk(ADD,  0, 1, 6, 7, 0, 0, 8, 0, 1, 0, 32'd0,        8, 32'h00010000, 0, 0);
    tbl[9]  = mk(ADD,  0, 0, 6, 7, 0, 0, 8, 0, 1, 0, 32'd0,        8, 32'h00020000, 0, 0);
    tbl[10] = mk(PASS, 0, 0, 0, 0, 0, 0, 9, 0, 1, 1, 32'h01010101, 9, 32'h01010101, 0, 0);
    tbl[11] = mk(SUB,  0, 2, 0, 9, 0, 0, 10, 0, 1, 1, 32'h0,       10, 32'hFFFFFFFF, 0, 0);
    tbl[12] = mk(SHR,  0, 2, 0, 0, 0, 0, 11, 0, 1, 1, 32'h80808080, 11, 32'h40404040, 0, 0);
    tbl[13] = mk(SHL,  0, 2, 0, 0, 0, 0, 12, 0, 1, 1, 32'h80808080, 12, 32'h0,       1, 0);
    tbl[14] = mk(ADD,  0, 0, 0, 7, 0, 0, 13, 0, 1, 1, 32'hFFFFFFFF, 13, 32'h0,       1, 1);
    tbl[15] = mk(ADD,  0, 0, 1, 2, 0, 0, 1, 0, 0, 0, 32'd0,        1, 32'd5,        1, 1);
    tbl[16] = mk(SUB,  0, 0, 4, 3, 0, 0, 14, 0, 1, 0, 32'd0,       14, 32'd5,       0, 1);
    tbl[17] = mk(ADD,  0, 0, 0, 14, 0, 0, 0, 0, 1, 1, 32'd3,       0, 32'd0,        0, 0);

    for (int i = 0; i < NREGS; i++) mregs[i] = '0;
    mz = 0; mc = 0; pend = '{default: '0};
    rst_n = 0; in_valid = 0; op = '0; form = 0; vec = '0;
    A = '0; B = '0; C = '0; D = '0; Y1 = '0; Y2 = '0; write = '0; const_a = 0;
    constant = '0; zero_mask = '0; dbg_addr = '0;

    tick(0);
    tick(3);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_zero", {31'b0, zero_flag}, 32'd0);
    chk("reset_carry", {31'b0, carry_flag}, 32'd0);
    chk("reset_reg3", dbg_data, 32'd0);
    rst_n = 1;
    zero_mask = 16'h0001;

    // Back-to-back issue; record i commits at the edge after record i+1 issues.
    for (int i = 0; i <= NT; i++) begin
      if (i < NT) drive(tbl[i]); else idle();
      tick(i > 0 ? tbl[i-1].chk : 4'd0);
      if (i > 0) begin
        chk($sformatf("tbl%0d_data", i-1), dbg_data, tbl[i-1].exp);
        chk($sformatf("tbl%0d_zero", i-1), {31'b0, zero_flag}, {31'b0, tbl[i-1].ez});
        chk($sformatf("tbl%0d_carry", i-1), {31'b0, carry_flag}, {31'b0, tbl[i-1].ec});
      end
    end
    idle();
    tick(5);
    chk("busy_falls", {31'b0, busy}, 32'd0);

    // Reset lands on the edge where the pending write would commit.
    drive(mk(PASS, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 32'd9, 1, 32'd0, 0, 0));
    tick(1);
    chk("midrst_busy_before", {31'b0, busy}, 32'd1);
    idle();
    rst_n = 0;
    tick(1);
    rst_n = 1;
    chk("midrst_reg1", dbg_data, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_zero", {31'b0, zero_flag}, 32'd0);
    chk("midrst_carry", {31'b0, carry_flag}, 32'd0);

    // Set both flags, then a write=00 instruction must leave regs and flags alone.
    drive(mk(SUB, 0, 0, 0, 15, 0, 0, 2, 0, 1, 1, 32'd0, 2, 32'd0, 1, 1));
    tick(2);
    drive(mk(PASS, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'd9, 1, 32'd0, 1, 1));
    tick(2);
    idle();
    tick(1);
    chk("wdis_reg1", dbg_data, 32'd0);
    chk("wdis_zero", {31'b0, zero_flag}, 32'd1);
    chk("wdis_carry", {31'b0, carry_flag}, 32'd1);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 500; n++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      op        = 3'($urandom);
      form      = 1'($urandom);
      vec       = 2'($urandom);
      A = 4'($urandom); B = 4'($urandom); C = 4'($urandom); D = 4'($urandom);
      Y1 = 4'($urandom); Y2 = ($urandom_range(0, 3) == 0) ? Y1 : 4'($urandom);
      write     = 2'($urandom);
      const_a   = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       constant = 32'h0;
        1:       constant = 32'hFFFFFFFF;
        2:       constant = 32'h80808080;
        default: constant = $urandom;
      endcase
      zero_mask = 16'($urandom & $urandom & $urandom);
      tick(4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
